// File: rtl/sram_responder.sv
// Synchronous SRAM target for the shared initiator bus: edge-committed writes,
// one-cycle-latency reads onto a tristate data bus, plus sticky bring-up status.
module sram_responder #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] adrx,
    input  logic              sramNotOutEn,
    input  logic              sramWrStrobe,
    inout  tri logic [DATA_W-1:0] data,
    output logic              rdValid,
    output logic              wrDone,
    output logic              conflict,
    output logic [CNT_W-1:0]  writeCount,
    output logic [CNT_W-1:0]  readCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        READ  = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_e            state_q, state_d;
    logic              strobe_prev_q;
    logic              rd_valid_q, rd_valid_d;
    logic              wr_done_q, wr_done_d;
    logic              conflict_q, conflict_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              mem_we;
    logic              rise;

    // Strobe history resets high so a strobe already at 1 out of reset is not a rise.
    assign rise = sramWrStrobe & ~strobe_prev_q;

    always_comb begin
        state_d    = state_q;
        rd_valid_d = rd_valid_q;
        wr_done_d  = 1'b0;
        conflict_d = conflict_q | (rise & ~sramNotOutEn);
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        rd_data_d  = rd_data_q;
        mem_we     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!sramNotOutEn) begin
                    state_d = READ;
                end else if (!sramWrStrobe) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (!sramNotOutEn) begin
                    state_d = READ;
                end else if (rise) begin
                    mem_we    = 1'b1;
                    wr_done_d = 1'b1;
                    wr_cnt_d  = sat_inc(wr_cnt_q);
                    state_d   = IDLE;
                end
            end
            READ: begin
                if (sramNotOutEn) begin
                    state_d    = IDLE;
                    rd_valid_d = 1'b0;
                end else begin
                    rd_data_d  = mem[adrx];
                    rd_valid_d = 1'b1;
                    rd_cnt_d   = sat_inc(rd_cnt_q);
                end
            end
            default: begin
                state_d    = IDLE;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            strobe_prev_q <= 1'b1;
            rd_valid_q    <= 1'b0;
            wr_done_q     <= 1'b0;
            conflict_q    <= 1'b0;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            strobe_prev_q <= sramWrStrobe;
            rd_valid_q    <= rd_valid_d;
            wr_done_q     <= wr_done_d;
            conflict_q    <= conflict_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Array has no reset so contents survive rst; reset forces IDLE, which blocks mem_we.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[adrx] <= data;
        end
    end

    // Released combinationally so the bus frees in the same cycle output enable drops.
    assign data = (~sramNotOutEn & rd_valid_q) ? rd_data_q : {DATA_W{1'bz}};

    assign rdValid    = rd_valid_q;
    assign wrDone     = wr_done_q;
    assign conflict   = conflict_q;
    assign writeCount = wr_cnt_q;
    assign readCount  = rd_cnt_q;

endmodule
